// File: rtl/spi2apb_burst_bridge.sv
// SPI mode-0 slave to APB master bridge with read-back, auto-increment bursts,
// APB wait-state/timeout handling and a sticky error flag.
module spi2apb_burst_bridge #(
    parameter int BANK_NUM    = 2,
    parameter int ADDR_WIDTH  = 7,
    parameter int PADDR_WIDTH = 3,
    parameter int PDATA_WIDTH = 8,
    parameter int TURNAROUND  = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sclk_i,
    input  logic                   ss_i,
    input  logic                   mosi_i,
    output logic                   miso_o,
    output logic [BANK_NUM-1:0]    psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [PADDR_WIDTH-1:0] paddr_o,
    output logic [PDATA_WIDTH-1:0] pwdata_o,
    input  logic [PDATA_WIDTH-1:0] prdata_i,
    input  logic                   pready_i,
    input  logic                   pslverr_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int BANK_BITS = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int HDR_W     = 1 + ADDR_WIDTH;
    localparam int SH_W      = (HDR_W > PDATA_WIDTH) ? HDR_W : PDATA_WIDTH;
    localparam int CNT_MAX0  = (HDR_W > TURNAROUND) ? HDR_W : TURNAROUND;
    localparam int CNT_MAX   = (CNT_MAX0 > PDATA_WIDTH) ? CNT_MAX0 : PDATA_WIDTH;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_TURN, S_WDATA, S_RDATA} spi_state_e;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;

    // [0],[1] synchroniser, [2] previous value for edge detection
    logic [2:0] sclk_q, ss_q;
    logic [1:0] mosi_q;

    spi_state_e             spi_q, spi_d;
    apb_state_e             apb_q, apb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SH_W-1:0]        sh_q, sh_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   load_pend_q, load_pend_d;
    logic [PDATA_WIDTH-1:0] miso_sh_q, miso_sh_d;
    logic [PDATA_WIDTH-1:0] rdbuf_q, rdbuf_d;
    logic                   req_q, req_d;
    logic                   req_write_q, req_write_d;
    logic [BANK_NUM-1:0]    req_psel_q, req_psel_d;
    logic [PADDR_WIDTH-1:0] req_paddr_q, req_paddr_d;
    logic [PDATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [BANK_NUM-1:0]    psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [PDATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [TO_W-1:0]        tcnt_q, tcnt_d;
    logic                   err_q, err_d;

    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    logic [SH_W-1:0]        sh_next;
    logic                   launch, l_write;
    logic [ADDR_WIDTH-1:0]  l_addr;
    logic [PDATA_WIDTH-1:0] l_data;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign mosi_s    = mosi_q[1];
    assign sh_next   = {sh_q[SH_W-2:0], mosi_s};

    function automatic logic dec_err(input logic [ADDR_WIDTH-1:0] a);
        logic [BANK_BITS:0] bank;
        bank = {1'b0, a[PADDR_WIDTH +: BANK_BITS]};
        return ((a >> (PADDR_WIDTH + BANK_BITS)) != '0) ||
               (bank >= (BANK_BITS + 1)'(BANK_NUM));
    endfunction

    always_comb begin
        spi_d       = spi_q;
        apb_d       = apb_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        load_pend_d = load_pend_q;
        miso_sh_d   = miso_sh_q;
        rdbuf_d     = rdbuf_q;
        req_d       = req_q;
        req_write_d = req_write_q;
        req_psel_d  = req_psel_q;
        req_paddr_d = req_paddr_q;
        req_data_d  = req_data_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        launch      = 1'b0;
        l_write     = 1'b0;
        l_addr      = addr_q;
        l_data      = '0;

        if (ss_rise) begin
            spi_d       = S_IDLE;
            cnt_d       = '0;
            load_pend_d = 1'b0;
            miso_sh_d   = '0;
        end else if (ss_fall) begin
            spi_d       = S_HDR;
            cnt_d       = '0;
            sh_d        = '0;
            load_pend_d = 1'b0;
        end else if (spi_q != S_IDLE && sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (spi_q)
                S_HDR: begin
                    sh_d = sh_next;
                    if (cnt_q == CNT_W'(HDR_W - 1)) begin
                        cnt_d  = '0;
                        addr_d = sh_next[ADDR_WIDTH-1:0];
                        if (sh_next[HDR_W-1]) begin
                            spi_d = S_WDATA;
                        end else begin
                            spi_d  = S_TURN;
                            launch = 1'b1;
                            l_addr = sh_next[ADDR_WIDTH-1:0];
                            addr_d = sh_next[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_TURN: begin
                    if (cnt_q == CNT_W'(TURNAROUND - 1)) begin
                        cnt_d       = '0;
                        spi_d       = S_RDATA;
                        load_pend_d = 1'b1;
                    end
                end
                S_WDATA: begin
                    sh_d = sh_next;
                    if (cnt_q == CNT_W'(PDATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        launch  = 1'b1;
                        l_write = 1'b1;
                        l_data  = sh_next[PDATA_WIDTH-1:0];
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end
                end
                S_RDATA: begin
                    if (cnt_q == CNT_W'(PDATA_WIDTH - 1)) begin
                        cnt_d       = '0;
                        load_pend_d = 1'b1;
                    end
                end
                default: spi_d = S_IDLE;
            endcase
        end else if (spi_q != S_IDLE && sclk_fall) begin
            // Word boundary: present buffered data and prefetch the next address.
            if (load_pend_q) begin
                miso_sh_d   = rdbuf_q;
                load_pend_d = 1'b0;
                launch      = 1'b1;
                addr_d      = addr_q + ADDR_WIDTH'(1);
            end else if (spi_q == S_RDATA) begin
                miso_sh_d = {miso_sh_q[PDATA_WIDTH-2:0], 1'b0};
            end
        end

        case (apb_q)
            A_IDLE: begin
                if (req_q) begin
                    apb_d    = A_SETUP;
                    psel_d   = req_psel_q;
                    paddr_d  = req_paddr_q;
                    pwrite_d = req_write_q;
                    if (req_write_q) pwdata_d = req_data_q;
                    req_d    = 1'b0;
                end
            end
            A_SETUP: begin
                apb_d     = A_ACCESS;
                penable_d = 1'b1;
                tcnt_d    = '0;
            end
            A_ACCESS: begin
                if (pready_i) begin
                    apb_d     = A_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (pslverr_i) err_d = 1'b1;
                    if (!pwrite_q) rdbuf_d = pslverr_i ? '1 : prdata_i;
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    apb_d     = A_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    err_d     = 1'b1;
                    if (!pwrite_q) rdbuf_d = '1;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: apb_d = A_IDLE;
        endcase

        // A rejected read still has to return something on miso.
        if (launch) begin
            if (dec_err(l_addr)) begin
                err_d = 1'b1;
                if (!l_write) rdbuf_d = '1;
            end else begin
                req_d       = 1'b1;
                req_write_d = l_write;
                req_psel_d  = BANK_NUM'(1) << l_addr[PADDR_WIDTH +: BANK_BITS];
                req_paddr_d = l_addr[PADDR_WIDTH-1:0];
                req_data_d  = l_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_q      <= '0;
            ss_q        <= '1;
            mosi_q      <= '0;
            spi_q       <= S_IDLE;
            apb_q       <= A_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            load_pend_q <= 1'b0;
            miso_sh_q   <= '0;
            rdbuf_q     <= '0;
            req_q       <= 1'b0;
            req_write_q <= 1'b0;
            req_psel_q  <= '0;
            req_paddr_q <= '0;
            req_data_q  <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], sclk_i};
            ss_q        <= {ss_q[1:0], ss_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            spi_q       <= spi_d;
            apb_q       <= apb_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            load_pend_q <= load_pend_d;
            miso_sh_q   <= miso_sh_d;
            rdbuf_q     <= rdbuf_d;
            req_q       <= req_d;
            req_write_q <= req_write_d;
            req_psel_q  <= req_psel_d;
            req_paddr_q <= req_paddr_d;
            req_data_q  <= req_data_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
        end
    end

    assign miso_o    = miso_sh_q[PDATA_WIDTH-1];
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign busy_o    = (spi_q != S_IDLE) || (apb_q != A_IDLE) || req_q;
    assign err_o     = err_q;

endmodule
